// File: rtl/vga_pkg.sv
// Shared VGA geometry constants for the pixel pipeline.
package vga_pkg;
  localparam int H_PIXELS = 640;
  localparam int V_PIXELS = 480;
  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 525;
  localparam int RGB_W    = 8;
endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register used to align sync/blank/window flags with frame-memory data.
module vga_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_pipe [DEPTH];

  // Shift stage by stage; reset flushes every stage to the idle pattern.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= RESET_VAL;
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[DEPTH-1];
endmodule

// File: rtl/vga_frame_reader.sv
// Double-buffered grayscale frame reader: upscaled, centred image with delay-matched syncs.
// Optional VGA_READER_BORDER_EN draws a white 1-pixel ring around the image window.
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int          IMG_W      = 160,
  parameter int          IMG_H      = 120,
  parameter int          SCALE_LOG2 = 1,
  parameter int          MEM_LAT    = 2,
  parameter int          ADDR_W     = 16,
  parameter logic [23:0] BG_COLOR   = 24'h000040
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        x_vga,
  input  logic [9:0]        y_vga,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              flow_enabled,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              front_buf,
  output logic [RGB_W-1:0]  vga_r,
  output logic [RGB_W-1:0]  vga_g,
  output logic [RGB_W-1:0]  vga_b,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic              vga_blank_n
);
  localparam int WIN_W = IMG_W << SCALE_LOG2;
  localparam int WIN_H = IMG_H << SCALE_LOG2;
  localparam int X0    = (H_PIXELS - WIN_W) / 2;
  localparam int Y0    = (V_PIXELS - WIN_H) / 2;
  localparam logic [9:0] X0_V     = 10'(X0);
  localparam logic [9:0] X1_V     = 10'(X0 + WIN_W);
  localparam logic [9:0] Y0_V     = 10'(Y0);
  localparam logic [9:0] Y1_V     = 10'(Y0 + WIN_H);
  localparam logic [9:0] X_LAST   = 10'(H_PIXELS - 1);
  localparam logic [9:0] Y_VBLANK = 10'(V_PIXELS);
  localparam logic [9:0] SUB_MASK = 10'((1 << SCALE_LOG2) - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] BUF1_BASE = ADDR_W'(IMG_W * IMG_H);
  localparam int DL_DEPTH = MEM_LAT + 1;

  logic              w_in_x, w_in_y, w_in_win, w_last_sub;
  logic              w_frame_start, w_line_end, w_swap_now;
  logic [9:0]        w_dx, w_dy;
  logic [ADDR_W-1:0] w_col, w_buf_base;
  logic [ADDR_W-1:0] r_row_base, r_mem_addr;
  logic              r_mem_rd_en, r_front, r_pending, r_ack;
  logic [3:0]        w_dl_out;
  logic              w_d_hs, w_d_vs, w_d_blank_n, w_d_in_win, w_d_border;
  logic [23:0]       w_pix, r_pix;
  logic              r_hs, r_vs, r_blank_n;

  assign w_in_x        = (x_vga >= X0_V) && (x_vga < X1_V);
  assign w_in_y        = (y_vga >= Y0_V) && (y_vga < Y1_V);
  assign w_in_win      = w_in_x && w_in_y && flow_enabled;
  assign w_dx          = x_vga - X0_V;
  assign w_dy          = y_vga - Y0_V;
  assign w_col         = ADDR_W'(w_dx >> SCALE_LOG2);
  assign w_last_sub    = (w_dy & SUB_MASK) == SUB_MASK;
  assign w_frame_start = (x_vga == 10'd0) && (y_vga == 10'd0);
  assign w_line_end    = (x_vga == X_LAST);
  assign w_swap_now    = (x_vga == 10'd0) && (y_vga == Y_VBLANK) && (r_pending || swap_req);
  assign w_buf_base    = r_front ? BUF1_BASE : {ADDR_W{1'b0}};

  // Row base steps once per image row (after the last replicated scan line), no multiplier.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_row_base  <= {ADDR_W{1'b0}};
      r_mem_addr  <= {ADDR_W{1'b0}};
      r_mem_rd_en <= 1'b0;
    end else begin
      if (w_frame_start) r_row_base <= {ADDR_W{1'b0}};
      else if (w_line_end && w_in_y && w_last_sub) r_row_base <= r_row_base + ROW_STEP;
      r_mem_addr  <= w_buf_base + r_row_base + w_col;
      r_mem_rd_en <= w_in_win;
    end
  end

  // Buffer swap only at vertical-blank start; requests merge while pending.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_front   <= 1'b0;
      r_pending <= 1'b0;
      r_ack     <= 1'b0;
    end else begin
      r_ack <= w_swap_now;
      if (w_swap_now) begin
        r_front   <= ~r_front;
        r_pending <= 1'b0;
      end else if (swap_req) begin
        r_pending <= 1'b1;
      end
    end
  end

  vga_delay_line #(.WIDTH(4), .DEPTH(DL_DEPTH), .RESET_VAL(4'b1100)) u_dl (
    .clk   (clk),
    .reset (reset),
    .i_d   ({hsync_in, vsync_in, flow_enabled, w_in_win}),
    .o_q   (w_dl_out)
  );
  assign {w_d_hs, w_d_vs, w_d_blank_n, w_d_in_win} = w_dl_out;

`ifdef VGA_READER_BORDER_EN
  logic w_ring_x, w_ring_y, w_border;
  assign w_ring_x = (x_vga >= X0_V - 10'd1) && (x_vga <= X1_V);
  assign w_ring_y = (y_vga >= Y0_V - 10'd1) && (y_vga <= Y1_V);
  assign w_border = w_ring_x && w_ring_y && !(w_in_x && w_in_y) && flow_enabled;
  vga_delay_line #(.WIDTH(1), .DEPTH(DL_DEPTH), .RESET_VAL(1'b0)) u_dl_border (
    .clk   (clk),
    .reset (reset),
    .i_d   (w_border),
    .o_q   (w_d_border)
  );
`else
  assign w_d_border = 1'b0;
`endif

  // Pixel colour selection at the point where memory data and delayed flags line up.
  always_comb begin
    w_pix = BG_COLOR;
    if (!w_d_blank_n)     w_pix = 24'h000000;
    else if (w_d_in_win)  w_pix = {3{mem_rdata}};
    else if (w_d_border)  w_pix = 24'hFFFFFF;
    else                  w_pix = BG_COLOR;
  end

  // Final output register; this stage completes the MEM_LAT+2 latency.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pix     <= 24'h000000;
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_blank_n <= 1'b0;
    end else begin
      r_pix     <= w_pix;
      r_hs      <= w_d_hs;
      r_vs      <= w_d_vs;
      r_blank_n <= w_d_blank_n;
    end
  end

  assign mem_rd_en   = r_mem_rd_en;
  assign mem_addr    = r_mem_addr;
  assign swap_ack    = r_ack;
  assign front_buf   = r_front;
  assign {vga_r, vga_g, vga_b} = r_pix;
  assign vga_hsync   = r_hs;
  assign vga_vsync   = r_vs;
  assign vga_blank_n = r_blank_n;
endmodule

// File: tb/tb_vga_frame_reader.sv
// Scoreboard bench for vga_frame_reader: sparse per-line x sweep, swap handshake, resets.
module tb_vga_frame_reader;
  localparam int L = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  x_vga = 10'd700, y_vga = 10'd500;
  logic        hsync_in = 1'b1, vsync_in = 1'b1, flow_enabled = 1'b0, swap_req = 1'b0;
  logic        mem_rd_en, swap_ack, front_buf;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata, r_p0, r_p1;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hsync, vga_vsync, vga_blank_n;

  vga_frame_reader dut (
    .clk(clk), .reset(reset), .x_vga(x_vga), .y_vga(y_vga),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .flow_enabled(flow_enabled),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .swap_req(swap_req), .swap_ack(swap_ack), .front_buf(front_buf),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_blank_n(vga_blank_n)
  );

  always #5 clk = ~clk;

  // Frame memory model: returns addr[7:0], two cycles after the read strobe.
  always @(posedge clk) begin
    r_p0 <= mem_rd_en ? mem_addr[7:0] : 8'h00;
    r_p1 <= r_p0;
  end
  assign mem_rdata = r_p1;

  typedef struct { int due; logic rd; logic [15:0] addr; logic front; logic ack; } a_t;
  typedef struct { int due; logic hs; logic vs; logic bl; logic [23:0] rgb; } o_t;
  a_t aq[$];
  o_t oq[$];

  int n_tests = 0, n_fail = 0, cycn = 0;
  bit m_front = 1'b0, m_pend = 1'b0;
  int xs[14] = '{0, 1, 159, 160, 161, 162, 163, 479, 480, 639, 656, 657, 700, 752};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cycn, obs, exp);
    end
  endtask

  task automatic check_due();
    a_t a;
    o_t o;
    while (aq.size() > 0 && aq[0].due <= cycn) begin
      a = aq.pop_front();
      check_val("rd_en", {31'd0, mem_rd_en}, {31'd0, a.rd});
      if (a.rd) check_val("mem_addr", {16'd0, mem_addr}, {16'd0, a.addr});
      check_val("front_buf", {31'd0, front_buf}, {31'd0, a.front});
      check_val("swap_ack", {31'd0, swap_ack}, {31'd0, a.ack});
    end
    while (oq.size() > 0 && oq[0].due <= cycn) begin
      o = oq.pop_front();
      check_val("hsync", {31'd0, vga_hsync}, {31'd0, o.hs});
      check_val("vsync", {31'd0, vga_vsync}, {31'd0, o.vs});
      check_val("blank_n", {31'd0, vga_blank_n}, {31'd0, o.bl});
      check_val("rgb", {8'd0, vga_r, vga_g, vga_b}, {8'd0, o.rgb});
    end
  endtask

  // Drive one cycle of inputs (at a negedge) and push the expected results.
  task automatic drive(input int x, input int y, input bit sr);
    bit hs, vs, fe, in_x, in_y, win, ring, swap_now;
    int addr;
    a_t a;
    o_t o;
    hs = !(x >= 656 && x < 752);
    vs = !(y >= 490 && y < 492);
    fe = (x < 640) && (y < 480);
    x_vga = 10'(x); y_vga = 10'(y);
    hsync_in = hs; vsync_in = vs; flow_enabled = fe; swap_req = sr;
    in_x = (x >= 160) && (x < 480);
    in_y = (y >= 120) && (y < 360);
    win  = in_x && in_y && fe;
    ring = fe && (x >= 159) && (x <= 480) && (y >= 119) && (y <= 360) && !(in_x && in_y);
    addr = (m_front ? 19200 : 0) + ((y - 120) / 2) * 160 + (x - 160) / 2;
    swap_now = (x == 0) && (y == 480) && (m_pend || sr);
    if (swap_now) begin m_front = !m_front; m_pend = 1'b0; end
    else if (sr) m_pend = 1'b1;
    a.due = cycn + 1; a.rd = win; a.addr = 16'(addr); a.front = m_front; a.ack = swap_now;
    aq.push_back(a);
    o.due = cycn + L; o.hs = hs; o.vs = vs; o.bl = fe;
    if (!fe) o.rgb = 24'h000000;
    else if (win) o.rgb = {3{addr[7:0]}};
`ifdef VGA_READER_BORDER_EN
    else if (ring) o.rgb = 24'hFFFFFF;
`endif
    else o.rgb = 24'h000040;
    oq.push_back(o);
    cycn++;
  endtask

  task automatic cyc(input int x, input int y, input bit sr);
    @(negedge clk);
    check_due();
    drive(x, y, sr);
  endtask

  // Hold reset three cycles with inputs as they are, check idle outputs, resync the model.
  task automatic rst();
    @(negedge clk);
    check_due();
    reset = 1'b0; swap_req = 1'b0; cycn++;
    repeat (3) begin @(negedge clk); cycn++; end
    check_val("rst_hsync", {31'd0, vga_hsync}, 32'd1);
    check_val("rst_vsync", {31'd0, vga_vsync}, 32'd1);
    check_val("rst_blank_n", {31'd0, vga_blank_n}, 32'd0);
    check_val("rst_rgb", {8'd0, vga_r, vga_g, vga_b}, 32'd0);
    check_val("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    check_val("rst_addr", {16'd0, mem_addr}, 32'd0);
    check_val("rst_front", {31'd0, front_buf}, 32'd0);
    check_val("rst_ack", {31'd0, swap_ack}, 32'd0);
    aq.delete(); oq.delete();
    m_front = 1'b0; m_pend = 1'b0;
    reset = 1'b1;
    drive(int'(x_vga), int'(y_vga), 1'b0);
  endtask

  task automatic frame(input int sr1, input int sr2, input int rst_y);
    for (int y = 0; y < 525; y++) begin
      for (int k = 0; k < 14; k++) begin
        cyc(xs[k], y, (xs[k] == 0) && (y == sr1 || y == sr2));
        if (y == rst_y && xs[k] == 161) rst();
      end
    end
  endtask

  initial begin
    rst();
    frame(100, -1, -1);   // swap pending from mid-frame -> buffer 1
    frame(480, -1, -1);   // reads from 19200; request on the boundary itself -> buffer 0
    frame(10, 200, -1);   // two requests merge into one toggle -> buffer 1
    frame(50, -1, 60);    // mid-line reset drops pending and returns to buffer 0
    repeat (L + 2) cyc(700, 500, 1'b0);
    check_val("queues_drained", 32'(aq.size() + oq.size() > 2 * (L + 2) ? 1 : 0), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
